mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Single-port memory arbiter and access sequencer placed between the LC-3 datapath and the memory block. It shares the one memory port between the CPU datapath (MAR/MDR, MIO_EN, R_W) and a second bus master (DMA/display-refresh engine). It drives the memory enable and write strobes, counts the fixed memory latency, and generates the per-requester ready (R) pulse the control FSM waits on. The CPU has priority, bounded by a starvation limit for the device.

Parameters:
MEM_LAT, 3, memory access latency in cycles, legal range 1..15.
MAX_STREAK, 4, maximum consecutive CPU grants while the device is waiting, legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
cpu_req  input  1  CPU access request (MIO_EN), held until cpu_r
cpu_we  input  1  CPU write enable (R_W = 1 means write)
cpu_addr  input  16  CPU address (MAR)
cpu_wdata  input  16  CPU write data (MDR)
cpu_r  output  1  CPU ready, one-cycle pulse
dev_req  input  1  device access request, held until dev_r
dev_we  input  1  device write enable
dev_addr  input  16  device address
dev_wdata  input  16  device write data
dev_r  output  1  device ready, one-cycle pulse
rdata  output  16  registered read data, valid in the cycle ready pulses
mem_en  output  1  memory enable
mem_we  output  1  memory write strobe
mem_addr  output  16  memory address (registered)
mem_wdata  output  16  memory write data (registered)
mem_rdata  input  16  memory read data, valid on the last BUSY cycle
busy  output  1  access in flight (BUSY or DONE state)
owner  output  1  current or last grantee: 0 = CPU, 1 = device

Behaviour:
- Reset values: state IDLE; cpu_r, dev_r, mem_en, mem_we, busy, owner = 0; rdata, mem_addr, mem_wdata = 16'h0000; streak = 0; latency counter = 0.
- State IDLE:
  - No requests: stay in IDLE.
  - One or more requests: pick a winner, latch the winner's addr, wdata and we into the mem_* registers, set owner, load cnt = MEM_LAT-1, and go to BUSY.
- Arbitration, evaluated only in IDLE:
  - Only one requester active: that requester wins.
  - Both active: the CPU wins unless streak == MAX_STREAK, in which case the device wins.
  - Streak update: increment when the CPU wins while dev_req = 1; clear when the device wins; clear when the CPU wins with dev_req = 0.
- State BUSY:
  - mem_en = 1 and mem_we = latched we for every BUSY cycle. mem_addr and mem_wdata stay stable.
  - While cnt != 0: decrement cnt.
  - When cnt == 0: capture mem_rdata into rdata (reads only; rdata holds its value on writes) and go to DONE.
- State DONE:
  - mem_en = mem_we = 0.
  - Exactly one of cpu_r or dev_r pulses high, selected by owner.
  - Next state is IDLE, unconditionally.
- Latency: request sampled in IDLE at cycle t; BUSY occupies t+1 .. t+MEM_LAT; ready is high at t+MEM_LAT+1. A back-to-back access can start at t+MEM_LAT+2.
- Requester rules:
  - Hold req and its operands until ready.
  - Drop req in the cycle after ready. A req still high in IDLE is treated as a new request.
  - A req dropped mid-access does not abort the access: it completes and ready still pulses.
- The non-owner's ready stays 0 throughout. Both ready outputs are never high in the same cycle.
- Operand changes on the owner's inputs during BUSY are ignored, because they were latched in IDLE.
- Reset mid-access: the next cycle is IDLE with mem_en = 0 and no ready pulse. The in-flight access is dropped.
- Counter and streak widths are 4 bits. Neither wraps: streak saturates at MAX_STREAK.

Test Plan:
1. CPU read, MEM_LAT = 3: cpu_req = 1, cpu_we = 0, cpu_addr = 16'h3000, mem_rdata = 16'h1234 -> mem_en high for 3 cycles, mem_addr = 3000, cpu_r pulses 4 cycles after the request with rdata = 1234, dev_r = 0.
2. Device write: dev_req = 1, dev_we = 1, dev_addr = 16'hFE06, dev_wdata = 16'h0041 -> mem_we = 1 for 3 cycles, mem_wdata = 0041, dev_r pulses once, owner = 1.
3. Simultaneous requests at reset exit -> CPU granted first (owner = 0); the device is granted on the next IDLE once the CPU has dropped its request.
4. Starvation limit, MAX_STREAK = 4: cpu_req re-asserted immediately after every cpu_r, dev_req held high -> grant order CPU, CPU, CPU, CPU, DEV, then CPU again; streak reads 0 after the device grant.
5. Reset asserted on the 2nd BUSY cycle -> mem_en = 0 on the next cycle, state IDLE, no cpu_r or dev_r pulse, rdata = 0000.
6. Owner drops req mid-access, and operands change during BUSY -> mem_addr stays at the latched 3000, the access completes, and cpu_r still pulses exactly once.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles every signal between the memory port arbiter, its two requesters
//   (CPU datapath and device/DMA engine) and the memory block.
//   Modports:
//     slave  - the arbiter: samples requests and memory read data, drives
//              the memory strobes, ready pulses, read data and status.
//     master - the requester/memory side.
//   Signals:
//     cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request and operands, cpu_r ready pulse
//     dev_req/dev_we/dev_addr/dev_wdata  device request and operands, dev_r ready pulse
//     rdata                              registered read data
//     mem_en/mem_we/mem_addr/mem_wdata   memory port controls
//     mem_rdata                          memory read data
//     busy/owner                         access in flight, current/last grantee
interface mem_port_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_r;
    logic        dev_req;
    logic        dev_we;
    logic [15:0] dev_addr;
    logic [15:0] dev_wdata;
    logic        dev_r;
    logic [15:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dev_req, dev_we, dev_addr, dev_wdata,
        input  mem_rdata,
        output cpu_r, dev_r, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dev_req, dev_we, dev_addr, dev_wdata,
        output mem_rdata,
        input  cpu_r, dev_r, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single memory port between the CPU datapath and a device bus
//   master. Arbitration happens only in IDLE; the winner's operands are
//   latched, the memory is enabled for MEM_LAT cycles, and a one-cycle ready
//   pulse goes back to the owner. The CPU has priority, except that after
//   MAX_STREAK consecutive CPU grants with the device waiting, the device wins.
//   Ports:
//     clk    - system clock, rising edge
//     reset  - synchronous, active-high reset
//     bus    - mem_port_arbiter_if.slave (requests, memory port, status)
module mem_port_arbiter #(
    parameter int MEM_LAT    = 3,   // 1..15
    parameter int MAX_STREAK = 4    // 1..15
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  streak;
    logic        we_q;
    logic        owner_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;

    logic        grant;
    logic        grant_dev;
    logic        mem_en_c;
    logic        mem_we_c;
    logic        cpu_r_c;
    logic        dev_r_c;
    logic        busy_c;

    // Next state, arbitration and state-decoded outputs.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_dev = 1'b0;
        mem_en_c  = 1'b0;
        mem_we_c  = 1'b0;
        cpu_r_c   = 1'b0;
        dev_r_c   = 1'b0;
        busy_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_req || bus.dev_req) begin
                    grant     = 1'b1;
                    // Device wins when alone, or when the CPU streak has hit the limit.
                    grant_dev = bus.dev_req && (!bus.cpu_req || streak == STREAK_MAX);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_en_c = 1'b1;
                mem_we_c = we_q;
                busy_c   = 1'b1;
                if (cnt == 4'd0) state_nxt = DONE;
            end
            DONE: begin
                busy_c    = 1'b1;
                cpu_r_c   = !owner_q;
                dev_r_c   = owner_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            streak  <= 4'd0;
            we_q    <= 1'b0;
            owner_q <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner_q <= grant_dev;
                cnt     <= LAT_INIT;
                addr_q  <= grant_dev ? bus.dev_addr  : bus.cpu_addr;
                wdata_q <= grant_dev ? bus.dev_wdata : bus.cpu_wdata;
                we_q    <= grant_dev ? bus.dev_we    : bus.cpu_we;
                if (grant_dev || !bus.dev_req) begin
                    streak <= 4'd0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 4'd1;
                end
            end
            if (state == BUSY) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else if (!we_q) begin
                    // Memory data is valid on the last BUSY cycle only.
                    rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_r     = cpu_r_c;
    assign bus.dev_r     = dev_r_c;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_c;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with MEM_LAT = 3, MAX_STREAK = 4.
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MEM_LAT    (3),
        .MAX_STREAK (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_wdata = 16'h0000;
        bus.dev_req   = 1'b0;
        bus.dev_we    = 1'b0;
        bus.dev_addr  = 16'h0000;
        bus.dev_wdata = 16'h0000;
        bus.mem_rdata = 16'h0000;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) $display("FAIL rst_mem_en_we: got %b%b want 00", bus.mem_en, bus.mem_we); else pass_cnt++;
        total_cnt++; if (bus.cpu_r !== 1'b0 || bus.dev_r !== 1'b0) $display("FAIL rst_ready: got %b%b want 00", bus.cpu_r, bus.dev_r); else pass_cnt++;
        total_cnt++; if (bus.owner !== 1'b0) $display("FAIL rst_owner: got %b want 0", bus.owner); else pass_cnt++;
        total_cnt++; if (bus.rdata !== 16'h0000 || bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 16'h0000) $display("FAIL rst_data: got %h/%h/%h want 0000", bus.rdata, bus.mem_addr, bus.mem_wdata); else pass_cnt++;
    endtask

    task automatic test_cpu_read();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 16'h3000;
        bus.mem_rdata = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) $display("FAIL rd_en_busy%0d: got en=%b we=%b want en=1 we=0", i, bus.mem_en, bus.mem_we); else pass_cnt++;
            total_cnt++; if (bus.mem_addr !== 16'h3000) $display("FAIL rd_addr%0d: got %h want 3000", i, bus.mem_addr); else pass_cnt++;
            total_cnt++; if (bus.cpu_r !== 1'b0) $display("FAIL rd_early_r%0d: got %b want 0", i, bus.cpu_r); else pass_cnt++;
        end
        step();
        total_cnt++; if (bus.cpu_r !== 1'b1 || bus.dev_r !== 1'b0) $display("FAIL rd_ready: got cpu_r=%b dev_r=%b want 1/0", bus.cpu_r, bus.dev_r); else pass_cnt++;
        total_cnt++; if (bus.rdata !== 16'h1234) $display("FAIL rd_rdata: got %h want 1234", bus.rdata); else pass_cnt++;
        total_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL rd_done_en: got %b want 0", bus.mem_en); else pass_cnt++;
        bus.cpu_req = 1'b0;
        step();
        total_cnt++; if (bus.cpu_r !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rd_after: got cpu_r=%b busy=%b want 0/0", bus.cpu_r, bus.busy); else pass_cnt++;
    endtask

    task automatic test_dev_write();
        bus.dev_req   = 1'b1;
        bus.dev_we    = 1'b1;
        bus.dev_addr  = 16'hFE06;
        bus.dev_wdata = 16'h0041;
        bus.mem_rdata = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) $display("FAIL wr_strobe%0d: got en=%b we=%b want 1/1", i, bus.mem_en, bus.mem_we); else pass_cnt++;
            total_cnt++; if (bus.mem_addr !== 16'hFE06 || bus.mem_wdata !== 16'h0041) $display("FAIL wr_ops%0d: got %h/%h want fe06/0041", i, bus.mem_addr, bus.mem_wdata); else pass_cnt++;
            total_cnt++; if (bus.owner !== 1'b1) $display("FAIL wr_owner%0d: got %b want 1", i, bus.owner); else pass_cnt++;
        end
        step();
        total_cnt++; if (bus.dev_r !== 1'b1 || bus.cpu_r !== 1'b0) $display("FAIL wr_ready: got dev_r=%b cpu_r=%b want 1/0", bus.dev_r, bus.cpu_r); else pass_cnt++;
        total_cnt++; if (bus.mem_we !== 1'b0) $display("FAIL wr_done_we: got %b want 0", bus.mem_we); else pass_cnt++;
        total_cnt++; if (bus.rdata !== 16'h1234) $display("FAIL wr_rdata_hold: got %h want 1234", bus.rdata); else pass_cnt++;
        bus.dev_req = 1'b0;
        bus.dev_we  = 1'b0;
        step();
        total_cnt++; if (bus.dev_r !== 1'b0) $display("FAIL wr_single_pulse: got %b want 0", bus.dev_r); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        reset = 1'b1;
        step();
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h3000;
        bus.dev_req  = 1'b1;
        bus.dev_we   = 1'b0;
        bus.dev_addr = 16'hFE04;
        reset = 1'b0;
        step();
        total_cnt++; if (bus.owner !== 1'b0 || bus.mem_addr !== 16'h3000) $display("FAIL sim_first: got owner=%b addr=%h want 0/3000", bus.owner, bus.mem_addr); else pass_cnt++;
        step();
        step();
        step();
        total_cnt++; if (bus.cpu_r !== 1'b1 || bus.dev_r !== 1'b0) $display("FAIL sim_cpu_r: got cpu_r=%b dev_r=%b want 1/0", bus.cpu_r, bus.dev_r); else pass_cnt++;
        bus.cpu_req = 1'b0;
        step();
        step();
        total_cnt++; if (bus.owner !== 1'b1 || bus.mem_addr !== 16'hFE04) $display("FAIL sim_second: got owner=%b addr=%h want 1/fe04", bus.owner, bus.mem_addr); else pass_cnt++;
        step();
        step();
        step();
        total_cnt++; if (bus.dev_r !== 1'b1 || bus.cpu_r !== 1'b0) $display("FAIL sim_dev_r: got dev_r=%b cpu_r=%b want 1/0", bus.dev_r, bus.cpu_r); else pass_cnt++;
        bus.dev_req = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        logic exp_owner [6];
        exp_owner = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 16'h3000;
        bus.dev_req  = 1'b1;
        bus.dev_addr = 16'hFE04;
        for (int g = 0; g < 6; g++) begin
            step();
            total_cnt++; if (bus.owner !== exp_owner[g]) $display("FAIL starve_grant%0d: got owner=%b want %b", g, bus.owner, exp_owner[g]); else pass_cnt++;
            if (g == 4) begin
                total_cnt++; if (dut.streak !== 4'd0) $display("FAIL starve_streak_clr: got %0d want 0", dut.streak); else pass_cnt++;
            end
            step();
            step();
            step();
            if (exp_owner[g]) begin
                total_cnt++; if (bus.dev_r !== 1'b1 || bus.cpu_r !== 1'b0) $display("FAIL starve_ready%0d: got dev_r=%b cpu_r=%b want 1/0", g, bus.dev_r, bus.cpu_r); else pass_cnt++;
                bus.dev_req = 1'b0;
            end else begin
                total_cnt++; if (bus.cpu_r !== 1'b1 || bus.dev_r !== 1'b0) $display("FAIL starve_ready%0d: got cpu_r=%b dev_r=%b want 1/0", g, bus.cpu_r, bus.dev_r); else pass_cnt++;
            end
            if (g == 5) bus.cpu_req = 1'b0;
            step();
        end
    endtask

    task automatic test_reset_mid_access();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 16'h3000;
        bus.mem_rdata = 16'hCAFE;
        step();
        step();
        total_cnt++; if (bus.mem_en !== 1'b1) $display("FAIL rmid_busy2: got %b want 1", bus.mem_en); else pass_cnt++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.cpu_req = 1'b0;
        total_cnt++; if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rmid_idle: got en=%b busy=%b want 0/0", bus.mem_en, bus.busy); else pass_cnt++;
        total_cnt++; if (bus.rdata !== 16'h0000) $display("FAIL rmid_rdata: got %h want 0000", bus.rdata); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (bus.cpu_r !== 1'b0 || bus.dev_r !== 1'b0) $display("FAIL rmid_no_ready%0d: got %b%b want 00", i, bus.cpu_r, bus.dev_r); else pass_cnt++;
            step();
        end
    endtask

    task automatic test_drop_mid_access();
        int pulses;
        pulses = 0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 16'h3000;
        bus.cpu_wdata = 16'h1111;
        bus.mem_rdata = 16'h5A5A;
        step();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 16'h4000;
        bus.cpu_wdata = 16'h2222;
        for (int i = 0; i < 6; i++) begin
            if (bus.mem_en === 1'b1) begin
                total_cnt++; if (bus.mem_addr !== 16'h3000 || bus.mem_we !== 1'b0) $display("FAIL drop_ops%0d: got addr=%h we=%b want 3000/0", i, bus.mem_addr, bus.mem_we); else pass_cnt++;
            end
            if (bus.cpu_r === 1'b1) begin
                pulses++;
                total_cnt++; if (bus.rdata !== 16'h5A5A) $display("FAIL drop_rdata: got %h want 5a5a", bus.rdata); else pass_cnt++;
            end
            step();
        end
        total_cnt++; if (pulses !== 1) $display("FAIL drop_pulses: got %0d want 1", pulses); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL drop_idle: got busy=%b want 0", bus.busy); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        test_reset();
        test_cpu_read();
        test_dev_write();
        test_simultaneous();
        test_starvation();
        test_reset_mid_access();
        test_drop_mid_access();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
